// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory request/response bus between fetch_ctrl and imem
// master (fetch_ctrl): drives imem_req/imem_addr, receives imem_gnt/imem_rvalid/imem_rdata
// slave  (imem):       receives imem_req/imem_addr, drives imem_gnt/imem_rvalid/imem_rdata
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with one outstanding imem request and an in-order decode buffer
// Ports: clk, rstn (async active-low); redirect_valid/redirect_pc (branch/jump target);
//   imem (fetch_ctrl_if.master: req/addr/gnt/rvalid/rdata); id_valid/id_instr/id_pc/id_ready (decode);
//   misalign_trap/trap_pc (misaligned redirect report).
// Option: define FETCH_CTRL_ALIGN_CHECK_EN to trap on misaligned redirects and halt fetching until
//   an aligned redirect; otherwise redirect_pc[1:0] is ignored and the trap outputs are tied to 0.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  fetch_ctrl_if.master       imem,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  input  logic               id_ready,
  output logic               misalign_trap,
  output logic [31:0]        trap_pc
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(BUF_DEPTH);
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
  typedef enum logic {BOOT, RUN} state_t;
`endif
  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          outstanding;
  logic          discard;
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          pop;
  logic [31:0]   target;
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
  logic          misaligned;
  assign target     = redirect_pc;
  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign target        = redirect_pc & 32'hFFFF_FFFC;
  assign misalign_trap = 1'b0;
  assign trap_pc       = '0;
`endif
  assign imem.imem_req  = (state == RUN) && !outstanding && (count < FULL);
  assign imem.imem_addr = fetch_pc;
  assign grant    = imem.imem_req && imem.imem_gnt;
  assign rsp      = imem.imem_rvalid && outstanding;
  // a response arriving alongside a redirect is stale, so it is never buffered
  assign push     = rsp && !discard && !redirect_valid;
  assign pop      = id_valid && id_ready && !redirect_valid;
  assign id_valid = count != '0;
  assign id_pc    = buf_pc[rd_ptr];
  assign id_instr = buf_instr[rd_ptr];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
      misalign_trap <= 1'b0;
      trap_pc       <= '0;
`endif
    end else begin
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
      state <= redirect_valid ? (misaligned ? HALT : RUN) : (state == BOOT ? RUN : state);
      misalign_trap <= misaligned;
      if (misaligned) trap_pc <= redirect_pc;
`else
      state <= RUN;
`endif
      outstanding <= grant ? 1'b1 : rsp ? 1'b0 : outstanding;
      // a redirect poisons any request still in flight, unless its data lands this very cycle
      discard  <= redirect_valid ? ((outstanding && !rsp) || grant) : rsp ? 1'b0 : discard;
      fetch_pc <= redirect_valid ? target : grant ? fetch_pc + 32'd4 : fetch_pc;
      if (grant) req_pc <= fetch_pc;
      if (push) begin
        buf_pc[wr_ptr]    <= req_pc;
        buf_instr[wr_ptr] <= imem.imem_rdata;
      end
      rd_ptr <= redirect_valid ? '0 : rd_ptr + PW'(pop);
      wr_ptr <= redirect_valid ? '0 : wr_ptr + PW'(push);
      count  <= redirect_valid ? '0 : count + (PW + 1)'(push) - (PW + 1)'(pop);
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl with a queue-based reference model and directed scenarios
module tb_fetch_ctrl;
  localparam int DEPTH = 2;
  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} ent_t;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        misalign_trap;
  logic [31:0] trap_pc;
  int          checks = 0;
  int          errors = 0;
  logic        gnt_en = 1'b0;
  int          lat = 1;
  logic        pend = 1'b0;
  logic [31:0] pa = '0;
  int          pw = 0;
  logic [31:0] plog[$];
  logic [31:0] glog[$];
  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_rpc;
  logic [31:0] m_tpc;
  logic [31:0] m_old;
  logic        m_out, m_stale, m_boot, m_halt, m_trap, mg, mr, mp;
  fetch_ctrl_if bus();
  fetch_ctrl #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(bus), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .misalign_trap(misalign_trap), .trap_pc(trap_pc)
  );
  always #5 clk = ~clk;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction
  function automatic logic m_req();
    return m_boot && !m_halt && !m_out && (q.size() < DEPTH);
  endfunction
  // reference model: fetch PC, one in-flight slot with a stale flag, and a queue as the decode buffer
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      q.delete();
      m_pc = 32'h0; m_rpc = '0; m_tpc = '0;
      m_out = 0; m_stale = 0; m_boot = 0; m_halt = 0; m_trap = 0;
    end else begin
      mg = m_req() && bus.imem_gnt;
      mr = bus.imem_rvalid && m_out;
      mp = (q.size() != 0) && id_ready;
      m_old = m_pc;
      m_trap = 0;
      if (redirect_valid) begin
        q.delete();
        m_stale = (m_out && !mr) || mg;
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
        m_pc = redirect_pc;
        m_halt = redirect_pc[1:0] != 2'b00;
        if (m_halt) begin
          m_trap = 1;
          m_tpc = redirect_pc;
        end
`else
        m_pc = redirect_pc & ~32'h3;
`endif
      end else begin
        if (mp) void'(q.pop_front());
        if (mr) begin
          if (m_stale) m_stale = 0;
          else q.push_back({m_rpc, bus.imem_rdata});
        end
        if (mg) m_pc = m_pc + 32'd4;
      end
      if (mg) m_rpc = m_old;
      m_out = mg ? 1'b1 : mr ? 1'b0 : m_out;
      m_boot = 1;
    end
  always @(negedge clk) begin
    chk("imem_req", 32'(bus.imem_req), 32'(m_req()));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("id_pc", id_pc, q[0].pc);
      chk("id_instr", id_instr, q[0].ins);
    end
    chk("misalign_trap", 32'(misalign_trap), 32'(m_trap));
    chk("trap_pc", trap_pc, m_tpc);
  end
  always @(posedge clk)
    if (rstn && id_valid && id_ready && !redirect_valid) plog.push_back(id_pc);
  task automatic step();
    @(negedge clk);
    #1;
    redirect_valid = 1'b0;
    bus.imem_rvalid = 1'b0;
    if (pend) begin
      if (pw == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = ~pa;
        pend = 1'b0;
      end else pw--;
    end
    bus.imem_gnt = gnt_en;
    if (bus.imem_req && bus.imem_gnt) begin
      pend = 1'b1;
      pa = bus.imem_addr;
      pw = lat - 1;
      glog.push_back(bus.imem_addr);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    rstn = 1'b0;
    redirect_valid = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    pend = 1'b0;
    @(negedge clk);
    #1;
    rstn = 1'b1;
    plog.delete();
    glog.delete();
  endtask
  task automatic redirect(logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
  endtask
  task automatic wait_log(int n);
    for (int i = 0; i < 300 && plog.size() < n; i++) step();
    chk("log_wait", 32'(plog.size() >= n), 32'd1);
  endtask
  function automatic void chk_log(string n, int i, logic [31:0] e);
    chk(n, (i < plog.size()) ? plog[i] : 32'hDEAD_BEEF, e);
  endfunction
  initial begin
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_trap", 32'(misalign_trap), 0);
    chk("rst_trap_pc", trap_pc, 0);
    rstn = 1'b1;
    chk("boot_req", 32'(bus.imem_req), 0);
    gnt_en = 1'b1; lat = 1; id_ready = 1'b1;
    step();
    chk("first_req", 32'(bus.imem_req), 1);
    chk("first_addr", bus.imem_addr, 32'h0);
    wait_log(4);
    chk_log("seq0", 0, 32'h0); chk_log("seq1", 1, 32'h4);
    chk_log("seq2", 2, 32'h8); chk_log("seq3", 3, 32'hC);
    id_ready = 1'b0;
    do_reset();
    repeat (10) step();
    chk("full_req", 32'(bus.imem_req), 0);
    chk("full_addr", bus.imem_addr, 32'h8);
    chk("full_valid", 32'(id_valid), 1);
    chk("full_head", id_pc, 32'h0);
    id_ready = 1'b1;
    wait_log(3);
    chk_log("drain0", 0, 32'h0); chk_log("drain1", 1, 32'h4); chk_log("drain2", 2, 32'h8);
    lat = 3;
    do_reset();
    for (int i = 0; i < 100 && glog.size() < 2; i++) step();
    chk("t3_gnt4", (glog.size() >= 2) ? glog[1] : 32'hDEAD_BEEF, 32'h4);
    step();
    redirect(32'h100);
    wait_log(3);
    chk_log("inflight0", 0, 32'h0); chk_log("inflight1", 1, 32'h100); chk_log("inflight2", 2, 32'h104);
    lat = 1;
    do_reset();
    for (int i = 0; i < 100 && !(bus.imem_req && bus.imem_addr == 32'h8); i++) step();
    redirect(32'h100);
    step();
    chk("samecyc_addr", bus.imem_addr, 32'h100);
    chk("samecyc_req", 32'(bus.imem_req), 0);
    wait_log(3);
    chk_log("samecyc0", 0, 32'h0); chk_log("samecyc1", 1, 32'h100); chk_log("samecyc2", 2, 32'h104);
    plog.delete();
    step();
    redirect(32'hFFFF_FFF8);
    wait_log(3);
    chk_log("wrap0", 0, 32'hFFFF_FFF8); chk_log("wrap1", 1, 32'hFFFF_FFFC); chk_log("wrap2", 2, 32'h0);
    plog.delete();
    step();
    redirect(32'h102);
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    step();
    chk("mis_trap", 32'(misalign_trap), 1);
    chk("mis_trap_pc", trap_pc, 32'h102);
    chk("mis_req", 32'(bus.imem_req), 0);
    repeat (5) step();
    chk("halt_req", 32'(bus.imem_req), 0);
    chk("halt_trap", 32'(misalign_trap), 0);
    chk("halt_trap_pc", trap_pc, 32'h102);
    redirect(32'h200);
    wait_log(1);
    chk_log("resume0", 0, 32'h200);
`else
    wait_log(2);
    chk_log("mis0", 0, 32'h100); chk_log("mis1", 1, 32'h104);
`endif
    lat = 2;
    glog.delete();
    for (int i = 0; i < 100 && glog.size() < 1; i++) step();
    step();
    rstn = 1'b0;
    #1;
    chk("midrst_req", 32'(bus.imem_req), 0);
    chk("midrst_valid", 32'(id_valid), 0);
    chk("midrst_addr", bus.imem_addr, 32'h0);
    step();
    rstn = 1'b1;
    plog.delete();
    wait_log(2);
    chk_log("after_rst0", 0, 32'h0); chk_log("after_rst1", 1, 32'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
